// File: rtl/ldst_burst_unit_if.sv
// Operand/trigger/result bus of the load/store burst unit.
// master = datapath driving operands and consuming results, slave = the unit.
interface ldst_burst_unit_if #(
  parameter int DAT_W = 32,
  parameter int ADR_W = 7,
  parameter int BL_W  = 4
);
  logic             ldst_o_sel;
  logic [DAT_W-1:0] ldst_o_dat;
  logic             ldst_t_sel;
  logic [ADR_W-1:0] ldst_t_dat;
  logic [2:0]       ldst_typ_sel;
  logic [BL_W-1:0]  ldst_bl;
  logic [ADR_W-1:0] ldst_stride;
  logic [DAT_W-1:0] ldst_r_dat;
  logic             ldst_r_vld;
  logic             ldst_r_last;
  logic             ldst_r_rdy;
  logic             ldst_busy;
  logic             ldst_err;

  modport master (
    output ldst_o_sel, ldst_o_dat, ldst_t_sel, ldst_t_dat, ldst_typ_sel,
           ldst_bl, ldst_stride, ldst_r_rdy,
    input  ldst_r_dat, ldst_r_vld, ldst_r_last, ldst_busy, ldst_err
  );

  modport slave (
    input  ldst_o_sel, ldst_o_dat, ldst_t_sel, ldst_t_dat, ldst_typ_sel,
           ldst_bl, ldst_stride, ldst_r_rdy,
    output ldst_r_dat, ldst_r_vld, ldst_r_last, ldst_busy, ldst_err
  );
endinterface

// File: rtl/ldst_burst_unit.sv
// Load/store burst unit: single-port RAM, burst loads through a 2-entry result
// FIFO with back-pressure, burst stores. Define LDST_STRIDE_EN for strided addressing.
module ldst_burst_unit #(
  parameter int DAT_W     = 32,
  parameter int ADR_W     = 7,
  parameter int MAX_BURST = 8,
  parameter int BL_W      = 4
) (
  input logic             clk,
  input logic             rst,
  ldst_burst_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ST  = 3'b010;
  localparam logic [2:0] OP_BLD = 3'b011;
  localparam logic [2:0] OP_BST = 3'b100;

  function automatic logic [BL_W-1:0] eff_len(input logic [2:0] typ, input logic [BL_W-1:0] bl);
    if (typ == OP_BLD || typ == OP_BST) begin
      if (bl == '0) return BL_W'(1);
      if (bl > BL_W'(MAX_BURST)) return BL_W'(MAX_BURST);
      return bl;
    end
    return BL_W'(1);
  endfunction

  logic [DAT_W-1:0] mem_q [0:(1<<ADR_W)-1];
  logic [DAT_W-1:0] fifo_dat_q [2];
  logic [1:0]       fifo_last_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;
  state_t           state_q;
  logic [ADR_W-1:0] addr_q;
  logic [BL_W-1:0]  k_q, n_q;
  logic             err_q;
`ifdef LDST_STRIDE_EN
  logic [ADR_W-1:0] stride_q;
`else
  logic             unused_stride;
  assign unused_stride = ^bus.ldst_stride;
`endif

  logic             typ_legal, is_load_op, is_store_op, trig_ok;
  logic [BL_W-1:0]  n_trig, n_cur, k_cur;
  logic [ADR_W-1:0] stride_cur, cur_addr, next_addr;
  logic             pop, credit, issue, issue_last, ram_we, beat_last, head_last;

  always_comb begin
    typ_legal   = (bus.ldst_typ_sel != 3'b000) && (bus.ldst_typ_sel <= OP_BST);
    is_load_op  = (bus.ldst_typ_sel == OP_LD) || (bus.ldst_typ_sel == OP_BLD);
    is_store_op = (bus.ldst_typ_sel == OP_ST) || (bus.ldst_typ_sel == OP_BST);
    trig_ok     = bus.ldst_t_sel && (state_q == IDLE) && typ_legal;
    n_trig      = eff_len(bus.ldst_typ_sel, bus.ldst_bl);
    // In IDLE the trigger-cycle operands stand in for the not-yet-loaded registers
    n_cur       = (state_q == IDLE) ? n_trig : n_q;
    k_cur       = (state_q == IDLE) ? '0 : k_q;
    cur_addr    = (state_q == IDLE) ? bus.ldst_t_dat : addr_q;
`ifdef LDST_STRIDE_EN
    stride_cur  = (state_q == IDLE) ? bus.ldst_stride : stride_q;
`else
    stride_cur  = ADR_W'(1);
`endif
    next_addr   = cur_addr + stride_cur;
    beat_last   = (k_cur + BL_W'(1)) == n_cur;
    head_last   = fifo_last_q[rd_ptr_q];
    pop         = (occ_q != 2'd0) && bus.ldst_r_rdy;
    credit      = (occ_q != 2'd2) || pop;
    issue       = (trig_ok && is_load_op) ||
                  ((state_q == LOAD) && (k_q != n_q) && credit);
    issue_last  = issue && beat_last;
    ram_we      = !rst && bus.ldst_o_sel &&
                  ((trig_ok && is_store_op) || (state_q == STORE));
  end

  // RAM write port and read port; the read lands directly in the result FIFO
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[cur_addr] <= bus.ldst_o_dat;
    if (issue)  fifo_dat_q[wr_ptr_q] <= mem_q[cur_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      n_q         <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_last_q <= '0;
      err_q       <= 1'b0;
`ifdef LDST_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      err_q <= bus.ldst_t_sel && ((state_q != IDLE) || !typ_legal);
      if (issue) begin
        fifo_last_q[wr_ptr_q] <= issue_last;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, issue} - {1'b0, pop};
      if (issue || ram_we) begin
        addr_q <= next_addr;
        k_q    <= k_cur + BL_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (trig_ok) begin
            n_q <= n_trig;
`ifdef LDST_STRIDE_EN
            stride_q <= bus.ldst_stride;
`endif
            if (is_load_op) begin
              state_q <= LOAD;
            end else begin
              // A single store with data present finishes in its trigger cycle
              if (!(ram_we && beat_last)) state_q <= STORE;
              if (!ram_we) begin
                addr_q <= bus.ldst_t_dat;
                k_q    <= '0;
              end
            end
          end
        end
        LOAD: begin
          if (pop && head_last) state_q <= IDLE;
        end
        STORE: begin
          if (ram_we && beat_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ldst_r_vld  = (occ_q != 2'd0);
  assign bus.ldst_r_dat  = bus.ldst_r_vld ? fifo_dat_q[rd_ptr_q] : '0;
  assign bus.ldst_r_last = bus.ldst_r_vld && head_last;
  assign bus.ldst_busy   = (state_q != IDLE) || (occ_q != 2'd0);
  assign bus.ldst_err    = err_q;
endmodule

// File: tb/tb_ldst_burst_unit.sv
// Bench for ldst_burst_unit: randomized and directed load/store traffic checked
// against an array memory model with address/length rules computed arithmetically.
module tb_ldst_burst_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [128];
  logic [31:0] st_q [$];

  ldst_burst_unit_if #(.DAT_W(32), .ADR_W(7), .BL_W(4)) bus ();

  ldst_burst_unit #(.DAT_W(32), .ADR_W(7), .MAX_BURST(8), .BL_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [2:0] typ, input int bl);
    if (typ == 3'b011 || typ == 3'b100) begin
      if (bl == 0) return 1;
      if (bl > 8) return 8;
      return bl;
    end
    return 1;
  endfunction

  function automatic int eff_stride(input int s);
`ifdef LDST_STRIDE_EN
    return s;
`else
    return 1;
`endif
  endfunction

  task automatic trigger(input logic [2:0] typ, input int base, input int bl, input int strd);
    bus.ldst_t_sel   = 1'b1;
    bus.ldst_typ_sel = typ;
    bus.ldst_t_dat   = 7'(base);
    bus.ldst_bl      = 4'(bl);
    bus.ldst_stride  = 7'(strd);
  endtask

  // gapmode >= 0: fixed gap before beat 1 only; < 0: random gaps before every beat
  task automatic do_store(input logic [2:0] typ, input int base, input int bl, input int strd,
                          input int gapmode, input bit inject);
    int n, s, k, wt, c;
    logic [31:0] wdat;
    n = eff_len(typ, bl);
    s = eff_stride(strd);
    k = 0;
    c = 0;
    wt = (gapmode >= 0) ? 0 : int'($urandom_range(0, 2));
    trigger(typ, base, bl, strd);
    while (k < n && c < 100) begin
      if (wt == 0) begin
        wdat = (st_q.size() != 0) ? st_q.pop_front() : $urandom;
        bus.ldst_o_sel = 1'b1;
        bus.ldst_o_dat = wdat;
        ref_mem[(base + k * s) % 128] = wdat;
        k++;
        wt = (gapmode >= 0) ? ((k == 1) ? gapmode : 0) : int'($urandom_range(0, 2));
      end else begin
        bus.ldst_o_sel = 1'b0;
        bus.ldst_o_dat = $urandom;
        wt--;
      end
      if (inject && c == 1) trigger(3'b001, 0, 0, 1);
      @(negedge clk);
      bus.ldst_t_sel = 1'b0;
      if (inject && c == 1) chk("err_trig_busy", bus.ldst_err, 1'b1);
      if (inject && c == 2) chk("err_one_cycle", bus.ldst_err, 1'b0);
      if (k < n) chk("st_busy", bus.ldst_busy, 1'b1);
      c++;
    end
    bus.ldst_o_sel = 1'b0;
    chk("st_beats", k, n);
    chk("st_end_busy", bus.ldst_busy, 1'b0);
  endtask

  // mode 0: rdy held high (exact timing checked), 1: rdy toggles, 2: random rdy
  task automatic do_load(input logic [2:0] typ, input int base, input int bl, input int strd,
                         input int mode);
    int n, s, got, cyc;
    logic r;
    n = eff_len(typ, bl);
    s = eff_stride(strd);
    got = 0;
    trigger(typ, base, bl, strd);
    bus.ldst_r_rdy = 1'b0;
    @(negedge clk);
    bus.ldst_t_sel = 1'b0;
    cyc = 1;
    while (got < n && cyc < 200) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      bus.ldst_r_rdy = r;
      if (mode == 0) chk("ld_vld_stream", bus.ldst_r_vld, 1'b1);
      chk("ld_busy", bus.ldst_busy, 1'b1);
      if (bus.ldst_r_vld) begin
        chk("ld_dat", bus.ldst_r_dat, ref_mem[(base + got * s) % 128]);
        chk("ld_last", bus.ldst_r_last, (got == n - 1));
        if (mode == 0) chk("ld_beat_time", cyc, got + 1);
        if (r) got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ldst_r_rdy = 1'b0;
    chk("ld_all_beats", got, n);
    chk("ld_end_vld", bus.ldst_r_vld, 1'b0);
    chk("ld_end_busy", bus.ldst_busy, 1'b0);
    if (mode == 0) chk("ld_end_time", cyc, n + 1);
  endtask

  initial begin
    bus.ldst_o_sel = 1'b0;
    bus.ldst_o_dat = '0;
    bus.ldst_t_sel = 1'b0;
    bus.ldst_t_dat = '0;
    bus.ldst_typ_sel = '0;
    bus.ldst_bl = '0;
    bus.ldst_stride = '0;
    bus.ldst_r_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", bus.ldst_r_vld, 1'b0);
    chk("rst_last", bus.ldst_r_last, 1'b0);
    chk("rst_dat", bus.ldst_r_dat, 32'h0);
    chk("rst_busy", bus.ldst_busy, 1'b0);
    chk("rst_err", bus.ldst_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Fill the whole RAM so every later load has a known expectation
    for (int i = 0; i < 16; i++) do_store(3'b100, i * 8, 8, 1, 0, 1'b0);
    for (int i = 0; i < 8; i++) st_q.push_back(32'h10 + i);
    do_store(3'b100, 0, 8, 1, 0, 1'b0);

    do_load(3'b001, 0, 0, 1, 0);
    st_q.push_back(32'h0f0f0f0f);
    do_store(3'b010, 3, 0, 1, 0, 1'b0);
    st_q.push_back(32'h0f0f0f0e);
    do_store(3'b010, 4, 0, 1, 0, 1'b0);
    do_load(3'b001, 3, 0, 1, 0);
    do_load(3'b001, 4, 0, 1, 0);

    do_load(3'b011, 1, 4, 1, 0);
    do_load(3'b011, 1, 4, 1, 1);
    do_load(3'b011, 126, 4, 1, 0);
    do_load(3'b011, 0, 3, 3, 0);

    do_store(3'b100, 40, 3, 1, 2, 1'b1);
    do_load(3'b011, 40, 3, 1, 0);
    do_load(3'b011, 10, 0, 1, 0);
    do_load(3'b011, 20, 15, 1, 1);
    do_store(3'b100, 60, 15, 1, 0, 1'b0);
    do_load(3'b011, 60, 8, 1, 2);

    trigger(3'b111, 5, 2, 1);
    @(negedge clk);
    bus.ldst_t_sel = 1'b0;
    chk("err_illegal", bus.ldst_err, 1'b1);
    chk("illegal_no_busy", bus.ldst_busy, 1'b0);
    @(negedge clk);
    chk("err_illegal_clear", bus.ldst_err, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] typ;
      typ = 3'($urandom_range(1, 4));
      if (typ == 3'b001 || typ == 3'b011)
        do_load(typ, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 2)));
      else
        do_store(typ, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 127)), -1, 1'b0);
    end

    // Reset in the middle of a stalled burst load
    bus.ldst_r_rdy = 1'b0;
    trigger(3'b011, 0, 8, 1);
    @(negedge clk);
    bus.ldst_t_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", bus.ldst_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", bus.ldst_r_vld, 1'b0);
    chk("mid_rst_busy", bus.ldst_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", bus.ldst_r_vld, 1'b0);
    do_load(3'b011, 2, 3, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
